// File: rtl/memory_pkg.sv
// memory_pkg
// Shared definitions for the RAM arbiter and the masters that drive it.
//   OP_LOAD / OP_STORE : major opcodes a master decodes to drive i_WE
//   DEFAULT_ADDR_W/DATA_W : default bus widths
//   port_id_width()    : width of a port index, never narrower than 1 bit
package memory_pkg;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // A single port still needs a 1-bit id so the return tag has a home.
    function automatic int port_id_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The search for a requester starts at the registered
// pointer and wraps at NUM_PORTS; after a grant to port k the pointer moves
// to k+1 (mod NUM_PORTS), otherwise it holds.
//   CLK, RST     : clock, synchronous active-high reset (pointer -> 0)
//   i_REQ        : per-port request
//   i_ADVANCE    : allow the pointer to move past the granted port
//   o_GNT        : one-hot grant (combinational)
//   o_GNT_IDX    : binary index of the granted port (0 when none)
module rr_arbiter
    import memory_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int PID_W     = port_id_width(NUM_PORTS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_PORTS-1:0] i_REQ,
    input  logic                 i_ADVANCE,
    output logic [NUM_PORTS-1:0] o_GNT,
    output logic [PID_W-1:0]     o_GNT_IDX
);

    localparam logic [PID_W-1:0] LAST_PORT = PID_W'(NUM_PORTS - 1);

    logic [PID_W-1:0] ptr_q;
    logic [PID_W-1:0] ptr_d;
    logic             any_gnt;
    logic [PID_W-1:0] cand_idx;
    int               cand;

    always_comb begin
        o_GNT     = '0;
        o_GNT_IDX = '0;
        any_gnt   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Wrap explicitly at NUM_PORTS: the port count need not be a power of two.
            cand = int'(ptr_q) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = PID_W'(cand);
            if (!any_gnt && i_REQ[cand_idx]) begin
                any_gnt           = 1'b1;
                o_GNT[cand_idx]   = 1'b1;
                o_GNT_IDX         = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_ADVANCE && any_gnt) begin
            ptr_d = (o_GNT_IDX == LAST_PORT) ? '0 : o_GNT_IDX + PID_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/memory_ram_arbiter.sv
// memory_ram_arbiter
// Shares one single-port synchronous RAM among NUM_PORTS requesters with a
// request/grant handshake and round-robin fairness. The granted command is
// registered onto the RAM pins one cycle after the grant; reads are tagged
// with their port id and the tag travels down a RD_LATENCY-deep pipe so that
// the return strobe lines up with the RAM's read data.
//   CLK, RST                 : clock, synchronous active-high reset
//   i_REQ/i_WE/i_ADDR/...    : per-port request, packed port k at slice k
//   o_GNT                    : one-hot grant, transfer when i_REQ & o_GNT
//   o_RVALID / o_DATA_RD     : one-hot read return strobe, broadcast data
//   o_X_RAM_*                : registered RAM command
//   i_X_RAM_DATA_RD          : RAM read data, valid RD_LATENCY after command
module memory_ram_arbiter
    import memory_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            i_REQ,
    input  logic [NUM_PORTS-1:0]            i_WE,
    input  logic [NUM_PORTS*ADDR_W-1:0]     i_ADDR,
    input  logic [NUM_PORTS*DATA_W-1:0]     i_DATA_WR,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] i_BE,
    output logic [NUM_PORTS-1:0]            o_GNT,
    output logic [NUM_PORTS-1:0]            o_RVALID,
    output logic [DATA_W-1:0]               o_DATA_RD,
    output logic                            o_X_RAM_CE,
    output logic                            o_X_RAM_RD,
    output logic                            o_X_RAM_WR,
    output logic [ADDR_W-1:0]               o_X_RAM_ADDR,
    output logic [DATA_W/8-1:0]             o_X_RAM_BE,
    output logic [DATA_W-1:0]               o_X_RAM_DATA_WR,
    input  logic [DATA_W-1:0]               i_X_RAM_DATA_RD
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PID_W = port_id_width(NUM_PORTS);

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PID_W-1:0]     arb_idx;
    logic [NUM_PORTS-1:0] gnt;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .CLK       (CLK),
        .RST       (RST),
        .i_REQ     (i_REQ),
        .i_ADVANCE (1'b1),
        .o_GNT     (arb_gnt),
        .o_GNT_IDX (arb_idx)
    );

    // No grant is offered while reset is held, so nothing looks accepted.
    assign gnt   = RST ? '0 : arb_gnt;
    assign o_GNT = gnt;

    // Command stage
    logic              ce_q, rd_q, wr_q;
    logic              ce_d, rd_d, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [PID_W-1:0]  id_q, id_d;

    always_comb begin
        ce_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        be_d    = '0;
        wdata_d = '0;
        id_d    = arb_idx;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt[k]) begin
                ce_d   = 1'b1;
                wr_d   = i_WE[k];
                rd_d   = ~i_WE[k];
                addr_d = i_ADDR[k*ADDR_W +: ADDR_W];
                if (i_WE[k]) begin
                    be_d    = i_BE[k*BE_W +: BE_W];
                    wdata_d = i_DATA_WR[k*DATA_W +: DATA_W];
                end else begin
                    // Reads fetch the full word; write data is forced quiet.
                    be_d    = '1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ce_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            id_q    <= '0;
        end else begin
            ce_q    <= ce_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
        end
    end

    assign o_X_RAM_CE      = ce_q;
    assign o_X_RAM_RD      = rd_q;
    assign o_X_RAM_WR      = wr_q;
    assign o_X_RAM_ADDR    = addr_q;
    assign o_X_RAM_BE      = be_q;
    assign o_X_RAM_DATA_WR = wdata_q;

    // Return tag pipe: stage 0 is loaded on the same edge the RAM samples the
    // read, so the last stage is valid exactly when the RAM data is.
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [PID_W-1:0]      pipe_id_q [RD_LATENCY];

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_q;
            pipe_id_q[0]  <= id_q;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_id_q[s]  <= pipe_id_q[s-1];
            end
        end
    end

    logic             tail_vld;
    logic [PID_W-1:0] tail_id;

    assign tail_vld  = pipe_vld_q[RD_LATENCY-1];
    assign tail_id   = pipe_id_q[RD_LATENCY-1];
    assign o_DATA_RD = tail_vld ? i_X_RAM_DATA_RD : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rvalid
            assign o_RVALID[gi] = tail_vld && (tail_id == PID_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_memory_ram_arbiter.sv
module tb_memory_ram_arbiter;

    localparam int NP   = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int RDL  = 3;
    localparam int NCYC = 280;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NP-1:0]    i_REQ, i_WE;
    logic [NP*AW-1:0] i_ADDR;
    logic [NP*DW-1:0] i_DATA_WR;
    logic [NP*BW-1:0] i_BE;
    logic [NP-1:0]    o_GNT, o_RVALID;
    logic [DW-1:0]    o_DATA_RD;
    logic             o_X_RAM_CE, o_X_RAM_RD, o_X_RAM_WR;
    logic [AW-1:0]    o_X_RAM_ADDR;
    logic [BW-1:0]    o_X_RAM_BE;
    logic [DW-1:0]    o_X_RAM_DATA_WR;
    logic [DW-1:0]    i_X_RAM_DATA_RD;

    always #5 CLK = ~CLK;

    memory_ram_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LATENCY (RDL)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .i_REQ           (i_REQ),
        .i_WE            (i_WE),
        .i_ADDR          (i_ADDR),
        .i_DATA_WR       (i_DATA_WR),
        .i_BE            (i_BE),
        .o_GNT           (o_GNT),
        .o_RVALID        (o_RVALID),
        .o_DATA_RD       (o_DATA_RD),
        .o_X_RAM_CE      (o_X_RAM_CE),
        .o_X_RAM_RD      (o_X_RAM_RD),
        .o_X_RAM_WR      (o_X_RAM_WR),
        .o_X_RAM_ADDR    (o_X_RAM_ADDR),
        .o_X_RAM_BE      (o_X_RAM_BE),
        .o_X_RAM_DATA_WR (o_X_RAM_DATA_WR),
        .i_X_RAM_DATA_RD (i_X_RAM_DATA_RD)
    );

    typedef struct packed {
        logic          chk;
        logic          ce, rd, wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic          chk;
        logic [NP-1:0] rv;
        logic [DW-1:0] data;
    } ret_t;

    logic [NP-1:0] exp_gnt_q [$];
    cmd_t          exp_cmd_q [$];
    ret_t          exp_ret_q [$];

    // Reference memory (updated in grant order) and the RAM macro model
    // (driven only by the DUT's RAM pins).
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ram_env [16];
    logic [DW-1:0] rd_line [RDL];

    logic          pend [NP];
    logic          p_we [NP];
    logic [AW-1:0] p_addr [NP];
    logic [DW-1:0] p_data [NP];
    logic [BW-1:0] p_be [NP];

    int mptr, cyc, checks, failures;
    bit run;

    // RAM macro: samples the command on the edge, data appears RDL cycles
    // after the command cycle; filler cycles carry garbage.
    always @(posedge CLK) begin
        for (int i = RDL - 1; i > 0; i--) rd_line[i] = rd_line[i-1];
        if (o_X_RAM_CE && o_X_RAM_RD) rd_line[0] = ram_env[o_X_RAM_ADDR[5:2]];
        else                          rd_line[0] = $urandom;
        if (o_X_RAM_CE && o_X_RAM_WR) begin
            for (int b = 0; b < BW; b++)
                if (o_X_RAM_BE[b]) ram_env[o_X_RAM_ADDR[5:2]][8*b +: 8] = o_X_RAM_DATA_WR[8*b +: 8];
        end
        i_X_RAM_DATA_RD = rd_line[RDL-1];
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin
        logic [NP-1:0] eg;
        cmd_t ec;
        ret_t er;
        if (run) begin
            checks++;
            if (exp_gnt_q.size() == 0) begin
                failures++;
                $display("FAIL gnt_queue cyc=%0d actual=empty required=entry", cyc);
            end else begin
                eg = exp_gnt_q.pop_front();
                if (o_GNT !== eg) begin
                    failures++;
                    $display("FAIL grant cyc=%0d actual=%b required=%b", cyc, o_GNT, eg);
                end
            end
            if (exp_cmd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL cmd_queue cyc=%0d actual=empty required=entry", cyc);
            end else begin
                ec = exp_cmd_q.pop_front();
                if (ec.chk) begin
                    checks++;
                    if ({o_X_RAM_CE, o_X_RAM_RD, o_X_RAM_WR, o_X_RAM_ADDR, o_X_RAM_BE, o_X_RAM_DATA_WR} !==
                        {ec.ce, ec.rd, ec.wr, ec.addr, ec.be, ec.wdata}) begin
                        failures++;
                        $display("FAIL ram_cmd cyc=%0d actual ce/rd/wr=%b%b%b addr=%h be=%b wd=%h required ce/rd/wr=%b%b%b addr=%h be=%b wd=%h",
                                 cyc, o_X_RAM_CE, o_X_RAM_RD, o_X_RAM_WR, o_X_RAM_ADDR, o_X_RAM_BE, o_X_RAM_DATA_WR,
                                 ec.ce, ec.rd, ec.wr, ec.addr, ec.be, ec.wdata);
                    end
                end
            end
            if (exp_ret_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ret_queue cyc=%0d actual=empty required=entry", cyc);
            end else begin
                er = exp_ret_q.pop_front();
                if (er.chk) begin
                    checks++;
                    if ({o_RVALID, o_DATA_RD} !== {er.rv, er.data}) begin
                        failures++;
                        $display("FAIL read_return cyc=%0d actual rvalid=%b data=%h required rvalid=%b data=%h",
                                 cyc, o_RVALID, o_DATA_RD, er.rv, er.data);
                    end
                end
            end
        end
    end

    task automatic new_req(input int p);
        pend[p]   = 1'b1;
        p_we[p]   = ($urandom_range(0, 3) == 0);
        p_addr[p] = 32'h100 + ($urandom_range(0, 15) << 2);
        p_data[p] = $urandom;
        p_be[p]   = 4'($urandom_range(0, 15));
    endtask

    // Driver and reference model
    initial begin
        int   g, c, mode, w;
        logic [NP-1:0] eg;
        cmd_t ec, skip_c, idle_c;
        ret_t er, skip_r, idle_r;
        logic [DW-1:0] v;

        RST = 1'b1; i_REQ = '0; i_WE = '0; i_ADDR = '0; i_DATA_WR = '0; i_BE = '0;
        i_X_RAM_DATA_RD = '0;
        checks = 0; failures = 0; cyc = 0; mptr = 0; run = 1'b0;
        skip_c = '0; idle_c = '0; idle_c.chk = 1'b1;
        skip_r = '0; idle_r = '0; idle_r.chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = $urandom; ref_mem[i] = v; ram_env[i] = v;
        end
        for (int i = 0; i < RDL; i++) rd_line[i] = '0;
        for (int p = 0; p < NP; p++) begin
            pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_data[p] = '0; p_be[p] = '0;
        end

        for (int n = 0; n < NCYC; n++) begin
            @(posedge CLK);
            #1;
            cyc = n;
            run = 1'b1;
            // 0 random, 1 all ports request, 2 idle
            if ((n >= 100 && n < 120) || (n >= 150 && n < 160) || n == 161) mode = 1;
            else if ((n >= 120 && n < 130) || n >= 262)                    mode = 2;
            else                                                            mode = 0;

            if (n < 2 || n == 160) begin
                RST = 1'b1;
                for (int p = 0; p < NP; p++) pend[p] = 1'b0;
                mptr = 0;
                exp_cmd_q.delete();
                exp_cmd_q.push_back(skip_c);
                exp_ret_q.delete();
                exp_ret_q.push_back(skip_r);
                for (int i = 0; i < RDL; i++) exp_ret_q.push_back(idle_r);
            end else begin
                RST = 1'b0;
                for (int p = 0; p < NP; p++) begin
                    if (pend[p]) begin
                        if (mode == 2 || (mode == 0 && $urandom_range(0, 15) == 0)) pend[p] = 1'b0;
                    end else if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)) begin
                        new_req(p);
                    end
                end
            end

            for (int p = 0; p < NP; p++) begin
                i_REQ[p]                = pend[p];
                i_WE[p]                 = p_we[p];
                i_ADDR[p*AW +: AW]      = p_addr[p];
                i_DATA_WR[p*DW +: DW]   = p_data[p];
                i_BE[p*BW +: BW]        = p_be[p];
            end

            // Round robin: first requester at or after the pointer, modulo NP.
            g = -1;
            for (int i = 0; i < NP; i++) begin
                c = (mptr + i) % NP;
                if (g < 0 && pend[c]) g = c;
            end

            eg = '0; ec = idle_c; er = idle_r;
            if (g >= 0) begin
                eg[g]    = 1'b1;
                w        = int'(p_addr[g][5:2]);
                ec.ce    = 1'b1;
                ec.rd    = !p_we[g];
                ec.wr    = p_we[g];
                ec.addr  = p_addr[g];
                if (p_we[g]) begin
                    ec.be    = p_be[g];
                    ec.wdata = p_data[g];
                    for (int b = 0; b < BW; b++)
                        if (p_be[g][b]) ref_mem[w][8*b +: 8] = p_data[g][8*b +: 8];
                end else begin
                    ec.be    = 4'hF;
                    ec.wdata = '0;
                    er.rv[g] = 1'b1;
                    er.data  = ref_mem[w];
                end
                $display("cyc=%0d grant port=%0d %s addr=%h be=%b data=%h", n, g,
                         p_we[g] ? "WR" : "RD", p_addr[g], ec.be, p_we[g] ? p_data[g] : er.data);
                mptr    = (g + 1) % NP;
                pend[g] = 1'b0;
            end
            exp_gnt_q.push_back(eg);
            exp_cmd_q.push_back(ec);
            exp_ret_q.push_back(er);
        end

        @(negedge CLK);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_ram_arbiter.md
Name: memory_ram_arbiter

Overview:
Parametrised N-port arbiter that shares one single-port synchronous RAM among NUM_PORTS requesters, such as the instruction fetch, load/store unit and debug/DMA ports. It replaces opcode-steered muxing with a per-port request/grant handshake and round-robin fairness. It supports byte-enabled writes and tags in-flight reads so that each return is routed to its originator after a fixed RAM latency. It sits between the core's memory-stage masters and the RAM macro.

Parameters:
NUM_PORTS, 2, number of requesting ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
RD_LATENCY, 1, cycles from a command on the RAM outputs to valid i_X_RAM_DATA_RD (1..4)

Ports:
CLK  in  1  clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
i_REQ  in  NUM_PORTS  per-port request; held until granted
i_WE  in  NUM_PORTS  per-port 1 = write, 0 = read
i_ADDR  in  NUM_PORTS*ADDR_W  per-port address; port k occupies slice [k*ADDR_W +: ADDR_W]
i_DATA_WR  in  NUM_PORTS*DATA_W  per-port write data
i_BE  in  NUM_PORTS*DATA_W/8  per-port byte enables for writes
o_GNT  out  NUM_PORTS  one-hot grant; request accepted this cycle
o_RVALID  out  NUM_PORTS  one-hot read-return strobe
o_DATA_RD  out  DATA_W  read data, broadcast to all ports; valid where o_RVALID is set
o_X_RAM_CE  out  1  RAM chip enable
o_X_RAM_RD  out  1  RAM read enable
o_X_RAM_WR  out  1  RAM write enable
o_X_RAM_ADDR  out  ADDR_W  RAM address
o_X_RAM_BE  out  DATA_W/8  RAM byte enables
o_X_RAM_DATA_WR  out  DATA_W  RAM write data
i_X_RAM_DATA_RD  in  DATA_W  RAM read data

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: all outputs 0; round-robin pointer 0; return pipeline empty.
- Grant (combinational from i_REQ and pointer):
  - Search from the pointer upward, modulo NUM_PORTS. The first port with i_REQ=1 gets o_GNT=1.
  - At most one grant per cycle. If no port is requesting, o_GNT=0.
  - After a grant to port k, the pointer becomes (k+1) mod NUM_PORTS on the next edge. With no grant, the pointer holds.
- Handshake:
  - A transfer occurs on the edge where i_REQ[k] and o_GNT[k] are both 1.
  - A requester keeps i_REQ, i_WE, i_ADDR, i_DATA_WR and i_BE stable until that edge. It may present a new request in the following cycle.
  - Dropping i_REQ before grant is legal; no transfer occurs.
- Command stage (registered, 1-cycle latency):
  - On the edge after a grant: o_X_RAM_CE=1; o_X_RAM_WR=i_WE; o_X_RAM_RD=~i_WE; ADDR, BE and DATA_WR are taken from the granted port.
  - For reads, o_X_RAM_BE is all ones and o_X_RAM_DATA_WR is 0.
  - With no grant, CE, RD and WR are 0 and ADDR, BE and DATA_WR return to 0. They do not hold stale values.
- Read return:
  - Each issued read pushes {valid, port_id} into a RD_LATENCY-deep shift register aligned with the RAM.
  - When the entry emerges, o_RVALID[port_id]=1 for one cycle and o_DATA_RD=i_X_RAM_DATA_RD (combinational pass-through). Otherwise o_DATA_RD=0.
  - Total read latency from the grant edge is 1+RD_LATENCY cycles.
- Writes produce no return strobe.
- Throughput: one transfer per cycle; back-to-back reads fully pipelined.
- Simultaneous events: a return strobe for port k and a new grant to port k in the same cycle are both permitted.
- NUM_PORTS=1: the pointer is constant; a request is granted whenever asserted.
- Reset mid-operation: the command register is cleared, in-flight reads are discarded (no o_RVALID ever fires for them) and the pointer goes to 0. RAM contents are unaffected.
- Width rules: port_id is $clog2(NUM_PORTS) bits, minimum 1. Pointer increment wraps explicitly at NUM_PORTS, not at a power of two.

Decomposition:
- Shared package (memory_pkg):
  - opcode constants OP_LOAD=7'h03 and OP_STORE=7'h23, used by masters to drive i_WE
  - default ADDR_W and DATA_W
  - a helper function for port_id width
- Sub-module rr_arbiter (NUM_PORTS): i_REQ and advance in, one-hot o_GNT and the registered pointer. It is reused by later bus arbiters.

Test Plan:
- Single read: RD_LATENCY=1; port 0 reads 0x100 and the RAM returns 0xDEADBEEF → o_GNT[0] in cycle 0; RAM_RD/ADDR=0x100 in cycle 1; o_RVALID[0]=1 and o_DATA_RD=0xDEADBEEF in cycle 2.
- Fairness: NUM_PORTS=3 with all ports requesting continuously → grant sequence 0,1,2,0,1,2 with no port starved.
- Byte-enabled write: port 1 writes 0x11223344 to 0x40 with BE=4'b0011 → o_X_RAM_WR=1, o_X_RAM_BE=0011, o_X_RAM_DATA_WR=0x11223344 one cycle after grant; no o_RVALID.
- Interleaved reads: RD_LATENCY=3; reads granted to ports 1, 0, 1 on consecutive cycles → o_RVALID pulses 1, 0, 1 on cycles 4, 5, 6 with matching data.
- Reset flush: RST asserted while two reads are in flight → all outputs 0 the next cycle, no o_RVALID afterwards, and the first post-reset grant goes to port 0.
- Idle bus: no requests for 5 cycles → CE=RD=WR=0, ADDR=0, pointer unchanged.
